// File: rtl/lmarv_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : lmarv_pkg
//  Brief    : Shared types and constants for the LMARV-1 PC stage.
//  Revision : 1.0  initial release
// ============================================================================
package lmarv_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        EXEC  = 2'd2
    } pc_state_t;

    localparam int PC_STEP    = 4;
    localparam int SLICE_W    = 4;
    localparam int NUM_SLICES = 8;

    // Word-align an address by dropping the byte-offset bits.
    function automatic logic [31:0] align_word(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage
`default_nettype wire

// File: rtl/pc_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module   : pc_sequencer_if
//  Brief    : Fetch/execute handshake bundle between the PC stage and its peers.
//  Revision : 1.0  initial release
// ============================================================================
interface pc_sequencer_if;
    logic        fetch_valid;
    logic        fetch_ready;
    logic [31:0] pc;
    logic        exec_done;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        misalign;
    logic        wrapped;

    // master = PC sequencer, slave = fetch/execute side
    modport master (
        output fetch_valid, pc, misalign, wrapped,
        input  fetch_ready, exec_done, branch_taken, branch_target
    );

    modport slave (
        input  fetch_valid, pc, misalign, wrapped,
        output fetch_ready, exec_done, branch_taken, branch_target
    );
endinterface
`default_nettype wire

// File: rtl/pc_slice.sv
`default_nettype none
// ============================================================================
//  Module   : pc_slice
//  Brief    : 4-bit synchronous counter cell with parallel load and cep/cet
//             enables; STEP=4 holds the two low bits at zero.
//  Revision : 1.0  initial release
// ============================================================================
module pc_slice
    import lmarv_pkg::*;
#(
    parameter int STEP = 1
) (
    input  wire logic               clk,
    input  wire logic               rst,
    input  wire logic [SLICE_W-1:0] rst_val,
    input  wire logic               pe,
    input  wire logic [SLICE_W-1:0] d,
    input  wire logic               cep,
    input  wire logic               cet,
    output logic      [SLICE_W-1:0] q,
    output logic                    tc
);

    // Bits below the step size never toggle; they are forced to zero.
    localparam logic [SLICE_W-1:0] CNT_MASK = ~(SLICE_W'(STEP) - SLICE_W'(1));

    logic [SLICE_W-1:0] q_q;
    logic [SLICE_W-1:0] q_d;

    always_comb begin
        q_d = q_q;
        if (pe) begin
            q_d = d & CNT_MASK;
        end else if (cep && cet) begin
            q_d = (q_q + SLICE_W'(STEP)) & CNT_MASK;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            q_q <= rst_val & CNT_MASK;
        end else begin
            q_q <= q_d;
        end
    end

    assign q  = q_q;
    assign tc = cet && ((q_q | ~CNT_MASK) == {SLICE_W{1'b1}});

endmodule
`default_nettype wire

// File: rtl/pc_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : pc_sequencer
//  Brief    : LMARV-1 program counter: eight cascaded counter slices plus the
//             fetch/execute control FSM, misalign pulse and sticky wrap flag.
//  Revision : 1.0  initial release
// ============================================================================
module pc_sequencer
    import lmarv_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
    input wire logic          cp,
    input wire logic          mr,
    pc_sequencer_if.master    bus
);

    pc_state_t   state_q;
    pc_state_t   state_d;
    logic        misalign_q;
    logic        misalign_d;
    logic        wrapped_q;
    logic        wrapped_d;

    logic        inc_req;
    logic        load_req;
    logic        carry_out;
    logic [31:0] pc_w;
    logic [31:0] load_val;

    assign inc_req  = (state_q == EXEC) && bus.exec_done && !bus.branch_taken;
    assign load_req = (state_q == EXEC) && bus.exec_done &&  bus.branch_taken;
    assign load_val = align_word(bus.branch_target);

    // Each slice's cet is the previous slice's terminal count, so the whole
    // carry settles combinationally inside one cycle.
    for (genvar k = 0; k < NUM_SLICES; k++) begin : g_slice
        logic cet_k;
        logic tc_k;

        if (k == 0) begin : g_head
            assign cet_k = inc_req;
        end else begin : g_link
            assign cet_k = g_slice[k-1].tc_k;
        end

        pc_slice #(
            .STEP (k == 0 ? PC_STEP : 1)
        ) u_slice (
            .clk     (cp),
            .rst     (mr),
            .rst_val (RESET_VECTOR[SLICE_W*k +: SLICE_W]),
            .pe      (load_req),
            .d       (load_val[SLICE_W*k +: SLICE_W]),
            .cep     (1'b1),
            .cet     (cet_k),
            .q       (pc_w[SLICE_W*k +: SLICE_W]),
            .tc      (tc_k)
        );
    end

    assign carry_out = g_slice[NUM_SLICES-1].tc_k;

    always_comb begin
        state_d    = state_q;
        misalign_d = load_req && (bus.branch_target[1:0] != 2'b00);
        wrapped_d  = wrapped_q || carry_out;
        case (state_q)
            IDLE:    state_d = FETCH;
            FETCH:   if (bus.fetch_ready) state_d = EXEC;
            EXEC:    if (bus.exec_done)   state_d = FETCH;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge cp) begin
        if (mr) begin
            state_q    <= IDLE;
            misalign_q <= 1'b0;
            wrapped_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            misalign_q <= misalign_d;
            wrapped_q  <= wrapped_d;
        end
    end

    assign bus.fetch_valid = (state_q == FETCH);
    assign bus.pc          = pc_w;
    assign bus.misalign    = misalign_q;
    assign bus.wrapped     = wrapped_q;

endmodule
`default_nettype wire

// File: tb/tb_pc_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pc_sequencer
//  Brief    : Directed, table-driven self-checking bench for pc_sequencer.
//  Revision : 1.0  initial release
// ============================================================================
module tb_pc_sequencer;

    localparam logic [31:0] RV = 32'h0000_0100;

    logic clk = 1'b0;
    logic mr  = 1'b1;
    int   checks   = 0;
    int   failures = 0;

    pc_sequencer_if bus_if ();

    pc_sequencer #(
        .RESET_VECTOR (RV)
    ) dut (
        .cp  (clk),
        .mr  (mr),
        .bus (bus_if)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        mr;
        logic        fr;
        logic        ed;
        logic        bt;
        logic [31:0] tgt;
        logic        fv;
        logic [31:0] pc;
        logic        mis;
        logic        wr;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic r, input logic fr, input logic ed, input logic bt,
                       input logic [31:0] tgt, input logic fv, input logic [31:0] pc,
                       input logic mis, input logic wr);
        vec_t v;
        v.mr = r;  v.fr = fr; v.ed = ed; v.bt = bt; v.tgt = tgt;
        v.fv = fv; v.pc = pc; v.mis = mis; v.wr = wr;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic fr, input logic ed, input logic bt,
                         input logic [31:0] tgt);
        mr                   = r;
        bus_if.fetch_ready   = fr;
        bus_if.exec_done     = ed;
        bus_if.branch_taken  = bt;
        bus_if.branch_target = tgt;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Wait (bounded) for fetch_valid, accept the PC, then retire with the given branch.
    task automatic run_instr(input string name, input logic bt, input logic [31:0] tgt);
        int n;
        n = 0;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        while (!bus_if.fetch_valid && n < 10) begin
            step();
            n++;
        end
        if (!bus_if.fetch_valid) begin
            chk({name, "_fv_timeout"}, 32'(bus_if.fetch_valid), 32'd1);
        end
        drive(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
        step();
        drive(1'b0, 1'b0, 1'b1, bt, tgt);
        step();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        //   mr fr ed bt target          fv pc              mis wr
        add(1, 0, 0, 0, 32'h0,           0, RV,             0, 0);
        add(1, 1, 1, 1, 32'hDEAD_0000,   0, RV,             0, 0);
        add(0, 1, 0, 0, 32'h0,           1, RV,             0, 0);
        add(0, 1, 0, 0, 32'h0,           0, RV,             0, 0);
        add(0, 1, 1, 0, 32'h0,           1, 32'h0000_0104,  0, 0);
        add(0, 1, 0, 0, 32'h0,           0, 32'h0000_0104,  0, 0);
        add(0, 1, 1, 0, 32'h0,           1, 32'h0000_0108,  0, 0);
        add(0, 1, 0, 0, 32'h0,           0, 32'h0000_0108,  0, 0);
        add(0, 1, 1, 1, 32'h0FFF_FFFC,   1, 32'h0FFF_FFFC,  0, 0);
        add(0, 1, 0, 0, 32'h0,           0, 32'h0FFF_FFFC,  0, 0);
        add(0, 1, 0, 1, 32'h1234_5678,   0, 32'h0FFF_FFFC,  0, 0);
        add(0, 1, 1, 0, 32'h0,           1, 32'h1000_0000,  0, 0);
        add(0, 1, 0, 0, 32'h0,           0, 32'h1000_0000,  0, 0);
        add(0, 1, 1, 1, 32'hFFFF_FFFC,   1, 32'hFFFF_FFFC,  0, 0);
        add(0, 1, 0, 0, 32'h0,           0, 32'hFFFF_FFFC,  0, 0);
        add(0, 1, 1, 0, 32'h0,           1, 32'h0000_0000,  0, 1);
        add(0, 1, 0, 0, 32'h0,           0, 32'h0000_0000,  0, 1);
        add(0, 1, 1, 1, 32'h0000_2003,   1, 32'h0000_2000,  1, 1);
        for (int s = 0; s < 5; s++) begin
            add(0, 0, 1, 1, 32'h0000_4444, 1, 32'h0000_2000, 0, 1);
        end
        add(0, 1, 0, 0, 32'h0,           0, 32'h0000_2000,  0, 1);
        add(1, 0, 1, 1, 32'h0000_4000,   0, RV,             0, 0);
        add(0, 1, 1, 1, 32'h0000_4000,   1, RV,             0, 0);
        add(0, 0, 0, 0, 32'h0,           1, RV,             0, 0);

        drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        foreach (vecs[i]) begin
            drive(vecs[i].mr, vecs[i].fr, vecs[i].ed, vecs[i].bt, vecs[i].tgt);
            step();
            chk($sformatf("row%0d_fetch_valid", i), 32'(bus_if.fetch_valid), 32'(vecs[i].fv));
            chk($sformatf("row%0d_pc", i),          bus_if.pc,               vecs[i].pc);
            chk($sformatf("row%0d_misalign", i),    32'(bus_if.misalign),    32'(vecs[i].mis));
            chk($sformatf("row%0d_wrapped", i),     32'(bus_if.wrapped),     32'(vecs[i].wr));
        end

        // Branch to zero must not set the wrap flag.
        run_instr("br_zero", 1'b1, 32'h0000_0000);
        chk("br_zero_pc",      bus_if.pc,               32'h0000_0000);
        chk("br_zero_wrapped", 32'(bus_if.wrapped),     32'd0);
        chk("br_zero_fv",      32'(bus_if.fetch_valid), 32'd1);

        // Misaligned target in the top slice: one-cycle pulse, low bits dropped.
        run_instr("br_mis", 1'b1, 32'h8000_0001);
        chk("br_mis_pc",       bus_if.pc,               32'h8000_0000);
        chk("br_mis_pulse",    32'(bus_if.misalign),    32'd1);
        step();
        chk("br_mis_clear",    32'(bus_if.misalign),    32'd0);
        chk("br_mis_pc_hold",  bus_if.pc,               32'h8000_0000);

        run_instr("inc_after", 1'b0, 32'hFFFF_FFFF);
        chk("inc_after_pc",      bus_if.pc,             32'h8000_0004);
        chk("inc_after_mis",     32'(bus_if.misalign),  32'd0);
        chk("inc_after_wrapped", 32'(bus_if.wrapped),   32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pc_sequencer.md
# pc_sequencer

Program-counter stage for LMARV-1: a 32-bit PC built from cascaded 4-bit synchronous counter slices, plus a small control FSM that presents the PC to instruction fetch, waits for the instruction to finish, then increments by 4 or loads a branch target. It sits directly upstream of instruction fetch and is the consumer of 4-bit counter cells. The slice chain mirrors the discrete build: ripple-enable through terminal-count outputs, and parallel-load for branches.

## Interface
Parameters:
- `RESET_VECTOR`, 32'h0000_0000, PC value after reset; bits [1:0] must be 0.

Ports:
- `cp`  in  1  clock; all state changes on rising edge.
- `mr`  in  1  master reset, synchronous, active-high.
- `fetch_valid`  out  1  PC is presented for fetch.
- `fetch_ready`  in  1  fetch accepts the PC this cycle.
- `pc`  out  32  current program counter; bits [1:0] always 0.
- `exec_done`  in  1  current instruction retired; PC update requested.
- `branch_taken`  in  1  qualifies `exec_done`: load `branch_target` instead of incrementing.
- `branch_target`  in  32  branch destination.
- `misalign`  out  1  one-cycle pulse: a taken target had nonzero bits [1:0].
- `wrapped`  out  1  sticky: PC incremented past 32'hFFFF_FFFC.

## Operation
- FSM states:
  - IDLE: `fetch_valid`=0. Always goes to FETCH on the next edge.
  - FETCH: `fetch_valid`=1. On `fetch_valid & fetch_ready` → EXEC.
  - EXEC: `fetch_valid`=0. On `exec_done` → FETCH, and the PC update happens on that same edge.
- PC update in EXEC with `exec_done`:
  - `branch_taken`=0: pc ← pc + 4, modulo 2^32.
  - `branch_taken`=1: pc ← {`branch_target`[31:2], 2'b00}.
  - A target with bits [1:0] ≠ 0 still loads (low bits forced to 0) and pulses `misalign` for one cycle.
- The PC changes only at that edge; it is stable at all other times, including the whole FETCH state.
- Ignored inputs:
  - `exec_done` in IDLE or FETCH; `branch_taken`/`branch_target` without `exec_done`.
  - `fetch_ready` in IDLE or EXEC.
- Wrap-around: incrementing from 32'hFFFF_FFFC gives 0 and sets `wrapped`. Only `mr` clears `wrapped`. A branch to 0 does not set it.
- Slice chain:
  - Eight 4-bit slices; slice k holds pc[4k+3:4k].
  - Slice 0 steps by 4; its bits [1:0] are held at 0. Its carry-out is `cet & q[3:2]==2'b11`.
  - Slices 1–7 step by 1. Each slice's carry-out is `cet & q==4'hF`.
  - Slice k counts only when its `cet` is high; `cet` is the AND of all lower carry-outs. Slice 0's `cet` is the increment request.
  - The parallel load (`pe`) goes to all slices together and overrides counting.
- Reset (`mr`=1 at an edge), with priority over all other inputs including a mid-EXEC update:
  - pc ← `RESET_VECTOR`, state ← IDLE.
  - `fetch_valid`=0, `misalign`=0, `wrapped`=0.

## Timing
- All outputs are registered or decoded from registered state only. No combinational path from inputs to outputs.
- Reset values: `pc`=`RESET_VECTOR`, `fetch_valid`=0, `misalign`=0, `wrapped`=0, state IDLE.
- After `mr` deasserts: `fetch_valid` rises on the second rising edge (one cycle in IDLE).
- Handshake: `fetch_valid` holds and `pc` stays stable until the cycle in which `fetch_ready`=1. `fetch_valid` drops on the next edge.
- `exec_done` sampled at edge N:
  - new `pc`, `fetch_valid`=1 and any `misalign` pulse are all visible after edge N.
  - `misalign` clears after edge N+1.
- Fastest loop is 2 cycles per instruction: `fetch_ready` and `exec_done` each asserted on the first cycle possible.
- A carry from slice 0 to slice 7 settles within one cycle. No multi-cycle ripple is allowed.

## Structure
- Shared package `lmarv_pkg`:
  - FSM state enum `pc_state_t` (IDLE, FETCH, EXEC).
  - Constants `PC_STEP`=4 and `SLICE_W`=4.
- One sub-module, `pc_slice`: 4-bit synchronous counter with sync reset, parallel load `pe`, enables `cep`/`cet`, step parameter (1 or 4), reset-value input, carry-out `tc`.
- `pc_sequencer` holds the FSM, the `wrapped`/`misalign` registers, and a generate loop of eight `pc_slice` instances.

## Test plan
- Reset then straight-line run:
  - Stimulus: `RESET_VECTOR`=32'h0000_0100; hold `fetch_ready`=1; pulse `exec_done` in each EXEC cycle.
  - Required: `pc` sequence 0x100, 0x104, 0x108; one instruction every 2 cycles.
- Carry across all slices:
  - Stimulus: branch to 32'h0FFF_FFFC, then one increment.
  - Required: pc=32'h1000_0000; `wrapped`=0.
- Wrap-around:
  - Stimulus: branch to 32'hFFFF_FFFC, then one increment.
  - Required: pc=0; `wrapped`=1; `wrapped` survives a later branch; only `mr` clears it.
- Misaligned branch:
  - Stimulus: `branch_target`=32'h0000_2003 with `branch_taken`=1.
  - Required: pc=32'h0000_2000; `misalign` high for exactly 1 cycle.
- Handshake stall and stray inputs:
  - Stimulus: hold `fetch_ready`=0 for 5 cycles while pulsing `exec_done`.
  - Required: `fetch_valid` stays 1; `pc` unchanged; stray `exec_done` ignored.
- Reset mid-EXEC:
  - Stimulus: assert `mr` on the same edge as `exec_done` with `branch_taken`=1.
  - Required: pc=`RESET_VECTOR`; state IDLE; `fetch_valid`=0; `fetch_valid`=1 two edges after `mr` falls.
